// File: rtl/dram_wr_sched_if.sv
// ---------------------------------------------------------------------------
// dram_wr_sched_if
// Bundles the producer handshakes, the clear request and the RAM write-port
// signals of the DRAM write scheduler.
//   clear              : request a new init sweep
//   a_valid/a_ready    : producer A handshake, with a_addr/a_data payload
//   b_valid/b_ready    : producer B handshake, with b_addr/b_data payload
//   we/waddr/wdata     : registered write port toward the RAM
//   init_done          : RAM contents valid, producers may be served
// master modport = producers/environment, slave modport = scheduler.
// ---------------------------------------------------------------------------
interface dram_wr_sched_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 16
);
    logic              clear;
    logic              a_valid;
    logic              a_ready;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_data;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              init_done;

    modport master (
        output clear, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_ready, b_ready, we, waddr, wdata, init_done
    );

    modport slave (
        input  clear, a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_ready, b_ready, we, waddr, wdata, init_done
    );
endinterface

// File: rtl/dram_wr_sched.sv
// ---------------------------------------------------------------------------
// dram_wr_sched
// Write-side scheduler for a quad-port distributed RAM. Two producers share
// the single write port; requests are arbitrated round-robin and the write
// port is driven from registers. After reset and after every clear request
// the whole RAM is swept to INIT_VAL before producers are served.
// Ports:
//   clk  : rising-edge clock shared with the RAM
//   rst  : synchronous active-high reset
//   bus  : dram_wr_sched_if.slave (clear, A/B handshakes, we/waddr/wdata,
//          init_done)
// ---------------------------------------------------------------------------
module dram_wr_sched #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 16,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic           clk,
    input  logic           rst,
    dram_wr_sched_if.slave bus
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Sweep counter carries one spare bit; the sweep ends on the all-ones
    // address so the counter never wraps back into the address range.
    localparam logic [ADDR_W:0] LAST_CNT = {1'b0, {ADDR_W{1'b1}}};

    state_t            state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              rr_q, rr_d;          // 0 = A has priority, 1 = B
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              init_done_q, init_done_d;

    logic run_ok;
    logic a_rdy;
    logic b_rdy;

    // Grants are purely combinational from state, pointer and valids; a
    // clear in RUN blocks both sides so the cycle carries no transfer.
    always_comb begin
        run_ok = ~rst & (state_q == ST_RUN) & ~bus.clear;
        a_rdy  = run_ok & bus.a_valid & (~bus.b_valid | ~rr_q);
        b_rdy  = run_ok & bus.b_valid & (~bus.a_valid |  rr_q);
    end

    assign bus.a_ready   = a_rdy;
    assign bus.b_ready   = b_rdy;
    assign bus.we        = we_q;
    assign bus.waddr     = waddr_q;
    assign bus.wdata     = wdata_q;
    assign bus.init_done = init_done_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rr_d        = rr_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        init_done_d = init_done_q;

        unique case (state_q)
            ST_INIT: begin
                we_d    = 1'b1;
                waddr_d = cnt_q[ADDR_W-1:0];
                wdata_d = INIT_VAL;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.clear) begin
                    init_done_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_INIT;
                end else if (a_rdy) begin
                    we_d    = 1'b1;
                    waddr_d = bus.a_addr;
                    wdata_d = bus.a_data;
                end else if (b_rdy) begin
                    we_d    = 1'b1;
                    waddr_d = bus.b_addr;
                    wdata_d = bus.b_data;
                end
                // Pointer only advances when both sides competed.
                if ((a_rdy | b_rdy) && bus.a_valid && bus.b_valid) begin
                    rr_d = ~rr_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rr_q        <= 1'b0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rr_q        <= rr_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

endmodule

// File: tb/tb_dram_wr_sched.sv
// ---------------------------------------------------------------------------
// tb_dram_wr_sched
// Directed bench for dram_wr_sched with a behavioural 64x16 RAM attached to
// the write port. Inputs change 1 ns after a rising edge; registered outputs
// are sampled there, combinational readies 1 ns later.
// ---------------------------------------------------------------------------
module tb_dram_wr_sched;

    localparam int AW = 6;
    localparam int DW = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DW-1:0] mem [64];

    dram_wr_sched_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dram_wr_sched #(.ADDR_W(AW), .DATA_W(DW), .INIT_VAL(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM write port; read ports are asynchronous (mem[] read directly).
    always @(posedge clk) begin
        if (bus.we) mem[bus.waddr] <= bus.wdata;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.clear   = 1'b0;
        bus.a_valid = 1'b1;
        bus.a_addr  = 6'd7;
        bus.a_data  = 16'h7777;
        bus.b_valid = 1'b1;
        bus.b_addr  = 6'd8;
        bus.b_data  = 16'h8888;
        repeat (3) tick();
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", bus.we); end
        checks++; if (bus.waddr !== 6'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", bus.waddr); end
        checks++; if (bus.wdata !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0000", bus.wdata); end
        checks++; if (bus.init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done got %b want 0", bus.init_done); end
        checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got a=%b b=%b want 0/0", bus.a_ready, bus.b_ready);
        end
        rst = 1'b0;
    endtask

    // Valids stay high through the sweep: readiness must stay low anyway.
    task automatic test_init_sweep();
        for (int i = 0; i < 64; i++) begin
            #1;
            checks++; if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                errors++; $display("FAIL init_ready[%0d] got a=%b b=%b want 0/0", i, bus.a_ready, bus.b_ready);
            end
            tick();
            checks++; if (bus.we !== 1'b1 || bus.waddr !== i[5:0] || bus.wdata !== 16'h0) begin
                errors++; $display("FAIL init_write[%0d] got we=%b addr=%0d data=%h want 1/%0d/0000", i, bus.we, bus.waddr, bus.wdata, i);
            end
            checks++; if (bus.init_done !== (i == 63)) begin
                errors++; $display("FAIL init_done[%0d] got %b want %b", i, bus.init_done, (i == 63));
            end
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
    endtask

    task automatic test_single_write();
        bus.a_valid = 1'b1;
        bus.a_addr  = 6'd5;
        bus.a_data  = 16'hBEEF;
        #1;
        checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++; $display("FAIL single_ready got a=%b b=%b want 1/0", bus.a_ready, bus.b_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.we !== 1'b1 || bus.waddr !== 6'd5 || bus.wdata !== 16'hBEEF) begin
            errors++; $display("FAIL single_write got we=%b addr=%0d data=%h want 1/5/beef", bus.we, bus.waddr, bus.wdata);
        end
        tick();
        checks++; if (bus.we !== 1'b0 || bus.waddr !== 6'd5 || bus.wdata !== 16'hBEEF) begin
            errors++; $display("FAIL single_idle got we=%b addr=%0d data=%h want 0/5/beef", bus.we, bus.waddr, bus.wdata);
        end
        checks++; if (mem[5] !== 16'hBEEF) begin errors++; $display("FAIL single_ram got %h want beef", mem[5]); end
    endtask

    task automatic test_round_robin();
        bus.a_valid = 1'b1; bus.a_addr = 6'd1; bus.a_data = 16'h1111;
        bus.b_valid = 1'b1; bus.b_addr = 6'd2; bus.b_data = 16'h2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.a_ready !== (k % 2 == 0) || bus.b_ready !== (k % 2 == 1)) begin
                errors++; $display("FAIL rr_grant[%0d] got a=%b b=%b want a=%b b=%b", k, bus.a_ready, bus.b_ready, (k % 2 == 0), (k % 2 == 1));
            end
            tick();
            checks++; if (bus.we !== 1'b1 || bus.waddr !== ((k % 2 == 0) ? 6'd1 : 6'd2)
                          || bus.wdata !== ((k % 2 == 0) ? 16'h1111 : 16'h2222)) begin
                errors++; $display("FAIL rr_write[%0d] got we=%b addr=%0d data=%h", k, bus.we, bus.waddr, bus.wdata);
            end
        end
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        tick();
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rr_idle got we=%b want 0", bus.we); end
    endtask

    task automatic test_same_addr();
        bus.a_valid = 1'b1; bus.a_addr = 6'd9; bus.a_data = 16'hAAAA;
        bus.b_valid = 1'b1; bus.b_addr = 6'd9; bus.b_data = 16'hBBBB;
        #1;
        checks++; if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b0) begin
            errors++; $display("FAIL same_first got a=%b b=%b want 1/0", bus.a_ready, bus.b_ready);
        end
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.waddr !== 6'd9 || bus.wdata !== 16'hAAAA) begin
            errors++; $display("FAIL same_write_a got addr=%0d data=%h want 9/aaaa", bus.waddr, bus.wdata);
        end
        #1;
        checks++; if (bus.b_ready !== 1'b1) begin errors++; $display("FAIL same_second got b=%b want 1", bus.b_ready); end
        tick();
        bus.b_valid = 1'b0;
        checks++; if (bus.we !== 1'b1 || bus.waddr !== 6'd9 || bus.wdata !== 16'hBBBB) begin
            errors++; $display("FAIL same_write_b got we=%b addr=%0d data=%h want 1/9/bbbb", bus.we, bus.waddr, bus.wdata);
        end
        tick();
        checks++; if (mem[9] !== 16'hBBBB) begin errors++; $display("FAIL same_ram got %h want bbbb", mem[9]); end
    endtask

    task automatic test_clear();
        bus.a_valid = 1'b1; bus.a_addr = 6'd3; bus.a_data = 16'h3333;
        bus.clear   = 1'b1;
        #1;
        checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL clear_ready got %b want 0", bus.a_ready); end
        tick();
        bus.clear = 1'b0;
        checks++; if (bus.we !== 1'b0 || bus.init_done !== 1'b0) begin
            errors++; $display("FAIL clear_edge got we=%b init_done=%b want 0/0", bus.we, bus.init_done);
        end
        for (int i = 0; i < 64; i++) begin
            #1;
            checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL clear_sweep_ready[%0d] got %b want 0", i, bus.a_ready); end
            tick();
            checks++; if (bus.we !== 1'b1 || bus.waddr !== i[5:0] || bus.wdata !== 16'h0) begin
                errors++; $display("FAIL clear_sweep[%0d] got we=%b addr=%0d data=%h", i, bus.we, bus.waddr, bus.wdata);
            end
        end
        checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL clear_done got %b want 1", bus.init_done); end
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL clear_accept got %b want 1", bus.a_ready); end
        tick();
        bus.a_valid = 1'b0;
        checks++; if (bus.we !== 1'b1 || bus.waddr !== 6'd3 || bus.wdata !== 16'h3333) begin
            errors++; $display("FAIL clear_write got we=%b addr=%0d data=%h want 1/3/3333", bus.we, bus.waddr, bus.wdata);
        end
        tick();
        for (int i = 0; i < 64; i++) begin
            checks++; if (mem[i] !== ((i == 3) ? 16'h3333 : 16'h0000)) begin
                errors++; $display("FAIL clear_ram[%0d] got %h want %h", i, mem[i], ((i == 3) ? 16'h3333 : 16'h0000));
            end
        end
    endtask

    task automatic test_rst_mid_sweep();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            checks++; if (bus.waddr !== i[5:0]) begin errors++; $display("FAIL mid_pre[%0d] got %0d", i, bus.waddr); end
        end
        rst = 1'b1;
        tick();
        checks++; if (bus.we !== 1'b0 || bus.waddr !== 6'd0 || bus.init_done !== 1'b0) begin
            errors++; $display("FAIL mid_rst got we=%b addr=%0d done=%b want 0/0/0", bus.we, bus.waddr, bus.init_done);
        end
        tick();
        checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL mid_rst_hold got we=%b want 0", bus.we); end
        rst = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            checks++; if (bus.we !== 1'b1 || bus.waddr !== i[5:0]) begin
                errors++; $display("FAIL mid_sweep[%0d] got we=%b addr=%0d", i, bus.we, bus.waddr);
            end
        end
        checks++; if (bus.init_done !== 1'b1) begin errors++; $display("FAIL mid_done got %b want 1", bus.init_done); end
        // In RUN, rst alone must hold readiness low.
        bus.a_valid = 1'b1; bus.a_addr = 6'd4; bus.a_data = 16'h4444;
        rst = 1'b1;
        #1;
        checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL run_rst_ready got %b want 0", bus.a_ready); end
        rst = 1'b0;
        #1;
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL run_release_ready got %b want 1", bus.a_ready); end
        bus.a_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_init_sweep();
        test_single_write();
        test_round_robin();
        test_same_addr();
        test_clear();
        test_rst_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
